// File: rtl/cam_capture_ctrl_pkg.sv
// Shared defaults, FSM encoding and RGB565->RGB444 slice positions
// for the camera capture path, buffer and VGA blocks.
package cam_capture_ctrl_pkg;

  localparam int CAM_AW    = 15;
  localparam int CAM_DW    = 12;
  localparam int CAM_IMG_W = 160;
  localparam int CAM_IMG_H = 120;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_VS_HI = 3'd1,
    S_WAIT_VS_LO = 3'd2,
    S_CAPTURE    = 3'd3,
    S_DONE       = 3'd4
  } cap_state_t;

  // b0 = RRRRRGGG, b1 = GGGBBBBB; keep the top bits of each field
  localparam int R_HI   = 7;
  localparam int R_LO   = 4;
  localparam int GH_HI  = 2;
  localparam int GH_LO  = 0;
  localparam int GL_BIT = 7;
  localparam int B_HI   = 4;
  localparam int B_LO   = 1;

endpackage

// File: rtl/cam_pixel_pack.sv
// Byte phase tracking and RGB565 -> RGB444 packing.
// pix_vld is combinational and marks the cycle the second byte is sampled.
module cam_pixel_pack
  import cam_capture_ctrl_pkg::*;
#(
  parameter int DW = CAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [DW-1:0] pix,
  output logic          pix_vld
);

  logic       phase;
  logic [6:0] b0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      b0_q  <= '0;
    end else if (!(en && href)) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
      if (!phase)
        b0_q <= {px_data[R_HI:R_LO], px_data[GH_HI:GH_LO]};
    end
  end

  assign pix_vld = en & href & phase;
  assign pix     = {b0_q, px_data[GL_BIT], px_data[B_HI:B_LO]};

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera byte stream to frame buffer write sequencer (RGB444, row-major).
// CAM_CAPTURE_CONTINUOUS_EN: capture every frame after one init.
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int AW    = CAM_AW,
  parameter int DW    = CAM_DW,
  parameter int IMG_W = CAM_IMG_W,
  parameter int IMG_H = CAM_IMG_H
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int BW = AW + 1;
  localparam logic [CW-1:0] W_MAX  = CW'(IMG_W);
  localparam logic [RW-1:0] H_MAX  = RW'(IMG_H);
  localparam logic [BW-1:0] W_STEP = BW'(IMG_W);

  cap_state_t    state, state_n;
  logic          busy_n;
  logic          href_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] row_base;
  logic          cap_en, frame_start, line_end, in_range;
  logic          pix_vld;
  logic [DW-1:0] pix;

  // vsync high inside CAPTURE ends the frame, so no pixel completes then
  assign cap_en      = (state == S_CAPTURE) && !vsync;
  assign frame_start = (state == S_WAIT_VS_LO) && !vsync;
  assign line_end    = cap_en && href_q && !href;
  assign in_range    = (col < W_MAX) && (row < H_MAX);

  cam_pixel_pack #(.DW(DW)) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cap_en),
    .href    (href),
    .px_data (px_data),
    .pix     (pix),
    .pix_vld (pix_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_n  = 1'b0;
    unique case (state)
      S_IDLE:       if (init)   state_n = S_WAIT_VS_HI;
      S_WAIT_VS_HI: if (vsync)  state_n = S_WAIT_VS_LO;
      S_WAIT_VS_LO: if (!vsync) state_n = S_CAPTURE;
      S_CAPTURE:    if (vsync)  state_n = S_DONE;
`ifdef CAM_CAPTURE_CONTINUOUS_EN
      S_DONE:       state_n = S_WAIT_VS_LO;
`else
      S_DONE:       state_n = S_IDLE;
`endif
      default:      state_n = S_IDLE;
    endcase
`ifdef CAM_CAPTURE_CONTINUOUS_EN
    busy_n = (state_n != S_IDLE);
`else
    busy_n = (state_n == S_WAIT_VS_HI) ||
             (state_n == S_WAIT_VS_LO) ||
             (state_n == S_CAPTURE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      href_q      <= 1'b0;
      col         <= '0;
      row         <= '0;
      row_base    <= '0;
    end else begin
      px_wr <= 1'b0;
      busy  <= busy_n;
      done  <= (state_n == S_DONE);
      if (state == S_IDLE && init)
        ovf <= 1'b0;
      if (frame_start) begin
        href_q   <= 1'b0;
        col      <= '0;
        row      <= '0;
        row_base <= '0;
        ovf      <= 1'b0;
      end else if (cap_en) begin
        href_q <= href;
        if (line_end) begin
          col <= '0;
          if (row < H_MAX) begin
            row      <= row + 1'b1;
            row_base <= row_base + W_STEP;
          end
        end else if (pix_vld) begin
          if (in_range) begin
            px_wr       <= 1'b1;
            mem_px_addr <= row_base[AW-1:0] + AW'(col);
            mem_px_data <= pix;
            col         <= col + 1'b1;
          end else begin
            ovf <= 1'b1;
          end
        end
      end else begin
        href_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Randomized frame stimulus against a per-line pixel model of the
// capture controller (IMG_W=4, IMG_H=2).
module tb_cam_capture_ctrl;

  localparam int AW = 15;
  localparam int DW = 12;
  localparam int IW = 4;
  localparam int IH = 2;
`ifdef CAM_CAPTURE_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, busy, done, ovf;

  cam_capture_ctrl #(
    .AW(AW), .DW(DW), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (init),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_a[$], obs_d[$], exp_a[$], exp_d[$];
  int lens[$];
  int done_cnt = 0;
  int busy_low = 0;
  bit exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int to444(input int b0, input int b1);
    int r5, g6, b5;
    r5 = (b0 >> 3) & 31;
    g6 = ((b0 & 7) << 3) | ((b1 >> 5) & 7);
    b5 = b1 & 31;
    return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
  endfunction

  always @(negedge clk) begin
    if (px_wr) begin
      obs_a.push_back(int'(mem_px_addr));
      obs_d.push_back(int'(mem_px_data));
    end
    if (done) done_cnt++;
    if (!busy) busy_low++;
  end

  task automatic pulse_init();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
    chk("busy_on", busy, 1);
    chk("ovf_clr", ovf, 0);
  endtask

  task automatic run_frame(input bit fixed, input bit poke_init);
    logic [7:0] lb[$];
    exp_a.delete(); exp_d.delete();
    obs_a.delete(); obs_d.delete();
    done_cnt = 0;
    exp_ovf  = 1'b0;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < lens.size(); l++) begin
      lb.delete();
      for (int i = 0; i < lens[l]; i++) begin
        href    = 1'b1;
        px_data = fixed ? ((i % 2) ? 8'h1F : 8'hF8) : 8'($urandom);
        lb.push_back(px_data);
        init = poke_init && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      href = 1'b0;
      init = 1'b0;
      for (int p = 0; p < lens[l] / 2; p++) begin
        if (l < IH && p < IW) begin
          exp_a.push_back(l * IW + p);
          exp_d.push_back(to444(lb[2*p], lb[2*p+1]));
        end else begin
          exp_ovf = 1'b1;
        end
      end
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bit exp_busy);
    int n;
    chk({tag, "_nwr"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, obs_a[i], exp_a[i]);
      chk({tag, "_data"}, obs_d[i], exp_d[i]);
    end
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_busy"}, busy, exp_busy);
  endtask

  task automatic reset_midframe();
    pulse_init();
    obs_a.delete(); obs_d.delete();
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40 && obs_a.size() < 3; i++) begin
      href    = 1'b1;
      px_data = 8'($urandom);
      @(negedge clk);
    end
    chk("rst_pre_wr", obs_a.size(), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", mem_px_addr, 0);
    chk("rst_data", mem_px_data, 0);
    chk("rst_ctl", {px_wr, busy, done, ovf}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin
      px_data = 8'($urandom);
      @(negedge clk);
    end
    href = 1'b0;
    @(negedge clk);
    chk("rst_nowr", obs_a.size(), 3);
    chk("rst_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_addr", mem_px_addr, 0);
    chk("reset_data", mem_px_data, 0);
    chk("reset_ctl", {px_wr, busy, done, ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    if (CONT) begin
      pulse_init();
      busy_low = 0;
      lens = '{8, 8};
      run_frame(1'b0, 1'b1);
      check_frame("c1", 1'b1);
      lens = '{6, 8};
      run_frame(1'b0, 1'b0);
      check_frame("c2", 1'b1);
      chk("c_busy_const", busy_low, 0);
    end else begin
      pulse_init();
      lens = '{8, 8};
      run_frame(1'b1, 1'b0);
      check_frame("fix", 1'b0);

      vsync = 1'b0;
      pulse_init();
      obs_a.delete(); obs_d.delete();
      repeat (2) begin
        href = 1'b1;
        repeat (6) begin
          px_data = 8'($urandom);
          @(negedge clk);
        end
        href = 1'b0;
        repeat (3) @(negedge clk);
      end
      chk("mid_nowr", obs_a.size(), 0);
      lens = '{8, 8};
      run_frame(1'b0, 1'b0);
      check_frame("mid", 1'b0);

      pulse_init();
      lens = '{10, 8};
      run_frame(1'b0, 1'b0);
      check_frame("long", 1'b0);

      pulse_init();
      lens = '{5, 8};
      run_frame(1'b0, 1'b0);
      check_frame("odd", 1'b0);

      pulse_init();
      lens = '{8, 8, 8};
      run_frame(1'b0, 1'b0);
      check_frame("xline", 1'b0);

      for (int f = 0; f < 6; f++) begin
        pulse_init();
        lens.delete();
        repeat ($urandom_range(1, 3))
          lens.push_back($urandom_range(1, 11));
        run_frame(1'b0, 1'b1);
        check_frame("rnd", 1'b0);
      end
    end

    reset_midframe();
    pulse_init();
    lens = '{8, 7};
    run_frame(1'b0, 1'b0);
    check_frame("post_rst", CONT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
